// File: rtl/rounding_arbiter_if.sv
// rounding_arbiter_if: requester, shared-rounder and result signals of rounding_arbiter.
// The master side drives samples, rounder results and downstream ready; the slave side is the arbiter.
interface rounding_arbiter_if #(
   parameter int N_CH = 4,
   parameter int WIDTH_IN = 32,
   parameter int WIDTH_OUT = 16
);
   localparam int CH_W = $clog2(N_CH);
   logic [N_CH-1:0] s_valid;
   logic [N_CH-1:0] s_ready;
   logic [N_CH*WIDTH_IN-1:0] s_data;
   logic rnd_ena;
   logic [WIDTH_IN-1:0] rnd_din;
   logic [WIDTH_OUT-1:0] rnd_dout;
   logic m_valid;
   logic m_ready;
   logic [WIDTH_OUT-1:0] m_data;
   logic [CH_W-1:0] m_chan;
   modport master (
      output s_valid, s_data, rnd_dout, m_ready,
      input s_ready, rnd_ena, rnd_din, m_valid, m_data, m_chan
   );
   modport slave (
      input s_valid, s_data, rnd_dout, m_ready,
      output s_ready, rnd_ena, rnd_din, m_valid, m_data, m_chan
   );
endinterface

// File: rtl/rounding_arbiter.sv
// rounding_arbiter: round-robin sharing of one pipelined rounder among N_CH sample streams.
// Defining ROUNDING_ARBITER_PERF_EN adds saturating transfer and stall counters.
module rounding_arbiter #(
   parameter int N_CH = 4,
   parameter int WIDTH_IN = 32,
   parameter int WIDTH_OUT = 16,
   parameter int RND_LAT = 2
) (
   input logic clk,
   input logic rst_n,
   rounding_arbiter_if.slave bus
`ifdef ROUNDING_ARBITER_PERF_EN
   ,
   output logic [31:0] perf_xfer_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);
   localparam int CH_W = $clog2(N_CH);
   logic adv, any, xfer;
   logic [CH_W-1:0] grant, ptr;
   logic [RND_LAT-1:0] vld;
   logic [CH_W-1:0] chan [RND_LAT];

   assign adv = !bus.m_valid | bus.m_ready;
   assign any = |bus.s_valid;
   assign xfer = adv & rst_n & any;

   // Scan from farthest to nearest so the first valid channel after ptr wins.
   always_comb begin
      grant = '0;
      for (int k = N_CH; k >= 1; k--)
         if (bus.s_valid[(int'(ptr) + k) % N_CH]) grant = CH_W'((int'(ptr) + k) % N_CH);
   end

   assign bus.s_ready = xfer ? {{(N_CH-1){1'b0}}, 1'b1} << grant : '0;
   assign bus.rnd_din = xfer ? bus.s_data[grant*WIDTH_IN +: WIDTH_IN] : '0;
   assign bus.rnd_ena = adv & rst_n;
   assign bus.m_data = bus.rnd_dout;
   assign bus.m_valid = vld[RND_LAT-1];
   assign bus.m_chan = chan[RND_LAT-1];

   // Tags advance in lockstep with the rounder stages, which also freeze on !adv.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= '0;
         ptr <= CH_W'(N_CH-1);
         for (int i = 0; i < RND_LAT; i++) chan[i] <= '0;
      end else if (adv) begin
         vld[0] <= xfer;
         chan[0] <= grant;
         for (int i = 1; i < RND_LAT; i++) begin
            vld[i] <= vld[i-1];
            chan[i] <= chan[i-1];
         end
         if (xfer) ptr <= grant;
      end
   end

`ifdef ROUNDING_ARBITER_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_xfer_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (xfer && perf_xfer_cnt != '1) perf_xfer_cnt <= perf_xfer_cnt + 32'd1;
         if (any && !adv && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_rounding_arbiter.sv
// tb_rounding_arbiter: directed scoreboard bench for rounding_arbiter with a 2-stage
// signed 32->16 ties-to-even rounder model; covers ROUNDING_ARBITER_PERF_EN when defined.
module tb_rounding_arbiter;
   localparam int N = 4;
   localparam int WI = 32;
   localparam int WO = 16;

   typedef struct packed {
      logic [1:0] ch;
      logic [WO-1:0] d;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rounding_arbiter_if #(.N_CH(N), .WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();
`ifdef ROUNDING_ARBITER_PERF_EN
   logic [31:0] perf_xfer_cnt, perf_stall_cnt;
`endif

   rounding_arbiter #(.N_CH(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .RND_LAT(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef ROUNDING_ARBITER_PERF_EN
      ,
      .perf_xfer_cnt(perf_xfer_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   function automatic logic [WO-1:0] rnd(input logic [WI-1:0] x);
      logic signed [WI-1:0] q;
      q = $signed(x) >>> 16;
      if (x[15:0] > 16'h8000 || (x[15:0] == 16'h8000 && q[0])) q = q + 1;
      return q[WO-1:0];
   endfunction

   // Shared rounder: two enabled register stages.
   logic [WO-1:0] r1 = '0, r2 = '0;
   always @(posedge clk)
      if (bus.rnd_ena) begin
         r1 <= rnd(bus.rnd_din);
         r2 <= r1;
      end
   assign bus.rnd_dout = r2;

   int checks = 0, failures = 0, cyc = 0;
   res_t sb[$];
   res_t olog[$];
   int glog[$], xfer_cyc[$], out_cyc[$];
   logic [1:0] mv = '0;
   int ptr_m = N - 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int ch, input logic [WI-1:0] v);
      bus.s_data[ch*WI +: WI] = v;
   endtask

   task automatic tick();
      logic adv_e, xfer_e;
      logic [N-1:0] rdy_e;
      int g;
      res_t e;
      @(negedge clk);
      adv_e = !mv[1] | bus.m_ready;
      g = -1;
      for (int k = N; k >= 1; k--) if (bus.s_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      xfer_e = rst_n & adv_e & (g >= 0);
      rdy_e = xfer_e ? 4'(1 << g) : 4'd0;
      chk("s_ready", 32'(bus.s_ready), 32'(rdy_e));
      chk("rnd_ena", 32'(bus.rnd_ena), 32'(rst_n & adv_e));
      chk("m_valid", 32'(bus.m_valid), 32'(mv[1]));
      if (xfer_e) chk("rnd_din", bus.rnd_din, bus.s_data[g*WI +: WI]);
      else chk("rnd_din_idle", bus.rnd_din, 32'd0);
      for (int i = 0; i < N; i++)
         if (bus.s_ready[i] && bus.s_valid[i]) begin
            glog.push_back(i);
            xfer_cyc.push_back(cyc);
         end
      if (mv[1]) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            chk("m_chan", 32'(bus.m_chan), 32'(sb[0].ch));
            chk("m_data", 32'(bus.m_data), 32'(sb[0].d));
            if (bus.m_ready) begin
               olog.push_back({bus.m_chan, bus.m_data});
               out_cyc.push_back(cyc);
               void'(sb.pop_front());
            end
         end
      end
      if (xfer_e) begin
         e.ch = 2'(g);
         e.d = rnd(bus.s_data[g*WI +: WI]);
         sb.push_back(e);
         ptr_m = g;
      end
      @(posedge clk);
      if (!rst_n) begin
         mv = '0;
         ptr_m = N - 1;
         sb.delete();
      end else if (adv_e) mv = {mv[0], xfer_e};
      cyc++;
      #1;
   endtask

   task automatic clear_logs();
      glog.delete();
      olog.delete();
      xfer_cyc.delete();
      out_cyc.delete();
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) set_data(i, $urandom);
   endtask

   initial begin
      bus.s_valid = '0;
      bus.s_data = '0;
      bus.m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.s_valid = 4'hF;
      tick();
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      rst_n = 1'b1;
      bus.s_valid = '0;
      tick();

      // 1: single channel, ties to even, latency
      clear_logs();
      bus.s_valid = 4'b0010;
      set_data(1, 32'h0001_8000);
      tick();
      set_data(1, 32'h0002_8000);
      tick();
      bus.s_valid = '0;
      repeat (3) tick();
      chk("t1_n_out", olog.size(), 32'd2);
      if (olog.size() == 2) begin
         chk("t1_res0", 32'(olog[0]), 32'h1_0002);
         chk("t1_res1", 32'(olog[1]), 32'h1_0002);
         chk("t1_latency", out_cyc[0] - xfer_cyc[0], 32'd2);
      end

      // 2: all channels, round-robin from ptr=1, one result per clock
      clear_logs();
      bus.s_valid = 4'hF;
      repeat (12) begin
         rand_data();
         tick();
      end
      bus.s_valid = '0;
      repeat (3) tick();
      chk("t2_n_grant", glog.size(), 32'd12);
      chk("t2_n_out", olog.size(), 32'd12);
      if (glog.size() == 12 && olog.size() == 12)
         for (int i = 0; i < 8; i++) begin
            chk("t2_grant", glog[i], (2 + i) % 4);
            chk("t2_chan", 32'(olog[i].ch), (2 + i) % 4);
            chk("t2_no_bubble", out_cyc[i+1] - out_cyc[i], 32'd1);
         end

      // 3: stall for 5 cycles mid-stream
      clear_logs();
      bus.s_valid = 4'hF;
      repeat (4) begin
         rand_data();
         tick();
      end
      bus.m_ready = 1'b0;
      repeat (5) begin
         rand_data();
         tick();
      end
      bus.m_ready = 1'b1;
      repeat (4) begin
         rand_data();
         tick();
      end
      bus.s_valid = '0;
      repeat (4) tick();
      chk("t3_no_loss", sb.size(), 32'd0);
      chk("t3_no_dup", olog.size(), glog.size());

      // 4: channels 2 and 3 alternate
      clear_logs();
      bus.s_valid = 4'b1100;
      repeat (6) begin
         rand_data();
         tick();
      end
      bus.s_valid = '0;
      repeat (3) tick();
      chk("t4_n_grant", glog.size(), 32'd6);
      if (glog.size() == 6)
         for (int i = 0; i < 5; i++) begin
            chk("t4_in_set", 32'(glog[i] >= 2), 32'd1);
            chk("t4_alt", glog[i+1], 5 - glog[i]);
         end

      // 5: reset with two samples in flight
      bus.s_valid = 4'hF;
      repeat (2) begin
         rand_data();
         tick();
      end
      rst_n = 1'b0;
      bus.m_ready = 1'b0;
      bus.s_valid = 4'b1001;
      tick();
      chk("t5_m_valid", 32'(bus.m_valid), 32'd0);
      rst_n = 1'b1;
      bus.m_ready = 1'b1;
      clear_logs();
      tick();
      bus.s_valid = '0;
      repeat (4) tick();
      chk("t5_first_grant", glog.size() > 0 ? glog[0] : -1, 32'd0);
      chk("t5_n_out", olog.size(), 32'd1);

`ifdef ROUNDING_ARBITER_PERF_EN
      // 6: perf counters
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_xfer_rst", perf_xfer_cnt, 32'd0);
      chk("t6_stall_rst", perf_stall_cnt, 32'd0);
      bus.s_valid = 4'b0001;
      repeat (10) begin
         rand_data();
         tick();
      end
      bus.m_ready = 1'b0;
      repeat (3) tick();
      bus.s_valid = '0;
      bus.m_ready = 1'b1;
      repeat (3) tick();
      chk("t6_xfer", perf_xfer_cnt, 32'd10);
      chk("t6_stall", perf_stall_cnt, 32'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_xfer_clr", perf_xfer_cnt, 32'd0);
      chk("t6_stall_clr", perf_stall_cnt, 32'd0);
`endif

      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
